// File: rtl/stream_mem_loader.sv
// Boot loader: packs a serial byte stream into words and writes them to
// consecutive memory addresses 0..last_addr, tracking checksum and overrun.
module stream_mem_loader #(
  parameter int unsigned BYTES_PER_WORD = 1,
  parameter int unsigned ADDR_W         = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_tick,
  input  logic [7:0]                  din,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           last_addr,
  output logic                        wen,
  output logic [ADDR_W-1:0]           addr,
  output logic [8*BYTES_PER_WORD-1:0] dout,
  output logic                        busy,
  output logic                        fin,
  output logic [7:0]                  csum,
  output logic                        ovf
);

  localparam int unsigned        DW        = 8 * BYTES_PER_WORD;
  localparam int unsigned        LANE_W    = 2;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DW-1:0]       word_q, word_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          csum_q, csum_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                ovf_q, ovf_d;

  function automatic logic [DW-1:0] put_lane(input logic [DW-1:0]     w,
                                             input logic [LANE_W-1:0] lane,
                                             input logic [7:0]        b);
    logic [DW-1:0] r;
    r = w;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == LANE_W'(i)) r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    fin_d   = fin_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_tick) begin
          fin_d  = 1'b0;
          ovf_d  = 1'b0;
          csum_d = din;
          busy_d = 1'b1;
          word_d = put_lane(word_q, '0, din);
          if (BYTES_PER_WORD == 1) begin
            wen_d   = 1'b1;
            dout_d  = word_d;
            state_d = S_WRITE;
          end else begin
            lane_d  = LANE_W'(1);
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (rx_tick) begin
          word_d = put_lane(word_q, lane_q, din);
          csum_d = csum_q + din;
          if (lane_q == LAST_LANE) begin
            wen_d   = 1'b1;
            dout_d  = word_d;
            lane_d  = '0;
            state_d = S_WRITE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (addr_q == last_addr) begin
          state_d = S_DONE;
          if (rx_tick) ovf_d = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          lane_d  = '0;
          state_d = S_COLLECT;
          // A byte landing here opens the next word; with one byte per word it completes it.
          if (rx_tick) begin
            word_d = put_lane(word_q, '0, din);
            csum_d = csum_q + din;
            if (BYTES_PER_WORD == 1) begin
              wen_d   = 1'b1;
              dout_d  = word_d;
              state_d = S_WRITE;
            end else begin
              lane_d = LANE_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
        if (rx_tick) ovf_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over any byte this cycle; flags, checksum and last data are kept.
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      lane_d  = '0;
      wen_d   = 1'b0;
      busy_d  = 1'b0;
      fin_d   = fin_q;
      csum_d  = csum_q;
      ovf_d   = ovf_q;
      word_d  = word_q;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wen  = wen_q;
  assign addr = addr_q;
  assign dout = dout_q;
  assign busy = busy_q;
  assign fin  = fin_q;
  assign csum = csum_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_stream_mem_loader.sv
// Bench for stream_mem_loader: three instances (1, 2 and 4 bytes per word) checked
// against expected word images and checksums derived from the byte stream.
module tb_stream_mem_loader;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, abort;
  logic [7:0]      din;
  logic [AW-1:0]   last_addr;
  logic            rx     [3];
  logic            wen_v  [3];
  logic            busy_v [3];
  logic            fin_v  [3];
  logic            ovf_v  [3];
  logic [AW-1:0]   addr_v [3];
  logic [7:0]      csum_v [3];
  logic [31:0]     dout_v [3];
  logic [7:0]      d1;
  logic [15:0]     d2;
  logic [31:0]     d4;

  assign dout_v[0] = {24'd0, d1};
  assign dout_v[1] = {16'd0, d2};
  assign dout_v[2] = d4;

  stream_mem_loader #(.BYTES_PER_WORD(1), .ADDR_W(AW)) u_b1 (
    .clk(clk), .rst(rst), .rx_tick(rx[0]), .din(din), .abort(abort), .last_addr(last_addr),
    .wen(wen_v[0]), .addr(addr_v[0]), .dout(d1), .busy(busy_v[0]), .fin(fin_v[0]),
    .csum(csum_v[0]), .ovf(ovf_v[0]));
  stream_mem_loader #(.BYTES_PER_WORD(2), .ADDR_W(AW)) u_b2 (
    .clk(clk), .rst(rst), .rx_tick(rx[1]), .din(din), .abort(abort), .last_addr(last_addr),
    .wen(wen_v[1]), .addr(addr_v[1]), .dout(d2), .busy(busy_v[1]), .fin(fin_v[1]),
    .csum(csum_v[1]), .ovf(ovf_v[1]));
  stream_mem_loader #(.BYTES_PER_WORD(4), .ADDR_W(AW)) u_b4 (
    .clk(clk), .rst(rst), .rx_tick(rx[2]), .din(din), .abort(abort), .last_addr(last_addr),
    .wen(wen_v[2]), .addr(addr_v[2]), .dout(d4), .busy(busy_v[2]), .fin(fin_v[2]),
    .csum(csum_v[2]), .ovf(ovf_v[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;
  wr_t mon_q[$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (wen_v[i] === 1'b1) mon_q.push_back('{i, addr_v[i], dout_v[i], cyc});
  end

  int checks = 0;
  int errors = 0;
  int bpw [3] = '{1, 2, 4};
  logic [7:0] bbuf [64];
  int         gbuf [64];
  int         tcyc [64];
  int         nb;

  // Called at a negedge; holds the strobe for exactly one sampling edge.
  task automatic send_byte(input int i, input logic [7:0] b, input int k);
    rx[i] = 1'b1;
    din   = b;
    tcyc[k] = cyc;
    @(negedge clk);
    rx[i] = 1'b0;
  endtask

  task automatic run_load(input int i, input int L, input string name);
    int          words, nbytes, fin_c, lastw_c;
    logic [31:0] exp_d;
    logic [7:0]  exp_cs;
    logic        exp_ovf;
    wr_t         w;
    words  = L + 1;
    nbytes = words * bpw[i];
    exp_d  = '0;
    mon_q.delete();
    last_addr = AW'(L);
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      send_byte(i, bbuf[k], k);
      if (k != nb - 1) repeat (gbuf[k]) @(negedge clk);
    end
    fin_c = -1;
    for (int t = 0; t < 40 && fin_c < 0; t++) begin
      if (fin_v[i] === 1'b1) fin_c = cyc;
      else @(negedge clk);
    end
    checks++;
    if (fin_c < 0) begin
      errors++;
      $display("FAIL %s fin_timeout: fin=%b required 1", name, fin_v[i]);
    end
    exp_cs = '0;
    for (int k = 0; k < nbytes && k < nb; k++) exp_cs = exp_cs + bbuf[k];
    exp_ovf = (nb > nbytes);
    checks++;
    if (mon_q.size() != words) begin
      errors++;
      $display("FAIL %s wen_count: got %0d required %0d", name, mon_q.size(), words);
    end
    lastw_c = -1;
    for (int k = 0; k < words && mon_q.size() > 0; k++) begin
      w = mon_q.pop_front();
      exp_d = '0;
      for (int j = 0; j < bpw[i]; j++) exp_d = exp_d | (32'(bbuf[k*bpw[i]+j]) << (8*j));
      checks++;
      if (w.idx != i || w.a !== AW'(k) || w.d !== exp_d) begin
        errors++;
        $display("FAIL %s write%0d: inst=%0d addr=%h data=%h required inst=%0d addr=%h data=%h",
                 name, k, w.idx, w.a, w.d, i, AW'(k), exp_d);
      end
      checks++;
      if (w.c != tcyc[(k+1)*bpw[i]-1] + 1) begin
        errors++;
        $display("FAIL %s latency%0d: wen at cycle %0d required %0d",
                 name, k, w.c, tcyc[(k+1)*bpw[i]-1] + 1);
      end
      lastw_c = w.c;
    end
    if (fin_c >= 0 && lastw_c >= 0) begin
      checks++;
      if (fin_c != lastw_c + 2) begin
        errors++;
        $display("FAIL %s fin_delay: fin at cycle %0d required %0d", name, fin_c, lastw_c + 2);
      end
    end
    checks++;
    if (csum_v[i] !== exp_cs || ovf_v[i] !== exp_ovf) begin
      errors++;
      $display("FAIL %s csum_ovf: csum=%h ovf=%b required csum=%h ovf=%b",
               name, csum_v[i], ovf_v[i], exp_cs, exp_ovf);
    end
    checks++;
    if (busy_v[i] !== 1'b0 || addr_v[i] !== '0 || dout_v[i] !== exp_d) begin
      errors++;
      $display("FAIL %s end_state: busy=%b addr=%h dout=%h required busy=0 addr=0 dout=%h",
               name, busy_v[i], addr_v[i], dout_v[i], exp_d);
    end
  endtask

  task automatic check_zero(input int i, input string name);
    checks++;
    if (wen_v[i] !== 1'b0 || addr_v[i] !== '0 || dout_v[i] !== '0 || busy_v[i] !== 1'b0 ||
        fin_v[i] !== 1'b0 || csum_v[i] !== '0 || ovf_v[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s inst%0d: wen=%b addr=%h dout=%h busy=%b fin=%b csum=%h ovf=%b required all 0",
               name, i, wen_v[i], addr_v[i], dout_v[i], busy_v[i], fin_v[i], csum_v[i], ovf_v[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
  endtask

  task automatic test_bpw1_spaced();
    nb = 4;
    bbuf[0] = 8'h11; bbuf[1] = 8'h22; bbuf[2] = 8'h33; bbuf[3] = 8'h44;
    for (int k = 0; k < 4; k++) gbuf[k] = 15;
    run_load(0, 3, "bpw1_spaced");
    checks++;
    if (csum_v[0] !== 8'hAA) begin
      errors++;
      $display("FAIL bpw1_csum: csum=%h required aa", csum_v[0]);
    end
  endtask

  task automatic test_bpw4_pack();
    nb = 8;
    for (int k = 0; k < 8; k++) begin bbuf[k] = 8'(k + 1); gbuf[k] = 1; end
    run_load(2, 1, "bpw4_pack");
  endtask

  task automatic test_write_cycle_byte();
    nb = 4;
    for (int k = 0; k < 4; k++) begin bbuf[k] = 8'($urandom); gbuf[k] = 3; end
    gbuf[1] = 0;
    run_load(1, 1, "write_cycle_byte");
  endtask

  task automatic test_overrun();
    nb = 2;
    bbuf[0] = 8'($urandom); bbuf[1] = 8'($urandom);
    gbuf[0] = 0;
    run_load(0, 0, "overrun");
    checks++;
    if (fin_v[0] !== 1'b1 || ovf_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flags: fin=%b ovf=%b required fin=1 ovf=1", fin_v[0], ovf_v[0]);
    end
    bbuf[0] = 8'h5A;
    send_byte(0, bbuf[0], 0);
    checks++;
    if (fin_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || csum_v[0] !== 8'h5A) begin
      errors++;
      $display("FAIL next_load_clear: fin=%b ovf=%b busy=%b csum=%h required fin=0 ovf=0 busy=1 csum=5a",
               fin_v[0], ovf_v[0], busy_v[0], csum_v[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] s;
    s = '0;
    mon_q.delete();
    last_addr = AW'(1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bbuf[k] = 8'($urandom);
      s = s + bbuf[k];
      send_byte(2, bbuf[k], k);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mon_q.size() != 0 || addr_v[2] !== '0 || busy_v[2] !== 1'b0 || fin_v[2] !== 1'b0 ||
        csum_v[2] !== s) begin
      errors++;
      $display("FAIL abort: writes=%0d addr=%h busy=%b fin=%b csum=%h required 0/0/0/0/%h",
               mon_q.size(), addr_v[2], busy_v[2], fin_v[2], csum_v[2], s);
    end
    nb = 8;
    for (int k = 0; k < 8; k++) begin bbuf[k] = 8'($urandom); gbuf[k] = $urandom_range(0, 2); end
    run_load(2, 1, "after_abort");
  endtask

  task automatic test_reset_mid_load();
    mon_q.delete();
    last_addr = AW'(1);
    @(negedge clk);
    send_byte(1, 8'hC3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero(1, "reset_mid_load");
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_load_writes: got %0d required 0", mon_q.size());
    end
    nb = 4;
    for (int k = 0; k < 4; k++) begin bbuf[k] = 8'($urandom); gbuf[k] = 2; end
    run_load(1, 1, "after_reset");
  endtask

  task automatic test_random_loads();
    int i, L;
    for (int it = 0; it < 8; it++) begin
      i  = $urandom_range(0, 2);
      L  = $urandom_range(0, 3);
      nb = (L + 1) * bpw[i];
      for (int k = 0; k < nb; k++) begin
        bbuf[k] = 8'($urandom);
        gbuf[k] = (bpw[i] == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      end
      run_load(i, L, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    din = '0;
    last_addr = '0;
    for (int i = 0; i < 3; i++) rx[i] = 1'b0;
    test_reset();
    test_bpw1_spaced();
    test_bpw4_pack();
    test_write_cycle_byte();
    test_overrun();
    test_abort();
    test_reset_mid_load();
    test_random_loads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
